// File: rtl/uart_inst_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_inst_loader_if                                       |
// | Brief   : Instruction BRAM write port driven by the UART loader     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface uart_inst_loader_if #(
  parameter int INST_SIZE = 14
);
  logic                 wr_en;
  logic [INST_SIZE-1:0] wr_addr;
  logic [31:0]          wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface
`default_nettype wire

// File: rtl/uart_inst_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_inst_loader                                          |
// | Brief   : UART 8N1 receiver feeding big-endian words into the BRAM  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module uart_inst_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int INST_SIZE        = 14
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  input  wire logic                 en,
  input  wire logic                 rxd,
  uart_inst_loader_if.master        bus,
  output logic [INST_SIZE:0]        word_count,
  output logic                      done,
  output logic                      overflow,
  output logic                      frame_err
);

  localparam int                C_TW        = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [C_TW-1:0]   C_HALF_LOAD = C_TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [C_TW-1:0]   C_FULL_LOAD = C_TW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [31:0]       C_SENTINEL  = 32'h0000_003F;
  localparam logic [INST_SIZE:0] C_CAPACITY = (INST_SIZE+1)'(1) << INST_SIZE;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_RECV  = 2'd1,
    L_WRITE = 2'd2,
    L_DONE  = 2'd3
  } ld_state_t;

  rx_state_t r_rx_state, w_rx_next;
  ld_state_t r_ld_state, w_ld_next;

  logic                 r_rxd_s1, r_rxd_s2, r_rxd_prev;
  logic [C_TW-1:0]      r_timer;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 w_byte_valid;
  logic                 w_stop_bad;
  logic                 w_timer_zero;
  logic                 w_rxd_fall;

  logic [23:0]          r_word;
  logic [1:0]           r_byte_cnt;
  logic [INST_SIZE-1:0] r_wr_addr;
  logic [31:0]          r_wr_data;
  logic [INST_SIZE:0]   w_count_inc;
  logic                 w_last_word;

  assign w_timer_zero = (r_timer == '0);
  assign w_rxd_fall   = r_rxd_prev & ~r_rxd_s2;
  assign w_count_inc  = word_count + (INST_SIZE+1)'(1);
  assign w_last_word  = (r_wr_data == C_SENTINEL) || (w_count_inc == C_CAPACITY);

  // Sync flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_s1   <= rxd;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_prev <= r_rxd_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_byte_valid = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rxd_fall) w_rx_next = RX_START;
      RX_START: if (w_timer_zero) w_rx_next = r_rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_timer_zero && r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_timer_zero) begin
          if (r_rxd_s2) begin
            w_rx_next    = RX_IDLE;
            w_byte_valid = 1'b1;
          end else begin
            w_rx_next  = RX_BREAK;
            w_stop_bad = 1'b1;
          end
        end
      end
      RX_BREAK: if (r_rxd_s2) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Timer is preloaded with the half period while idle, so START samples mid start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      frame_err <= 1'b0;
    end else begin
      if (r_rx_state == RX_IDLE || r_rx_state == RX_BREAK) r_timer <= C_HALF_LOAD;
      else if (w_timer_zero)                               r_timer <= C_FULL_LOAD;
      else                                                 r_timer <= r_timer - 1'b1;

      if (r_rx_state == RX_START) r_bit_cnt <= '0;
      else if (r_rx_state == RX_DATA && w_timer_zero) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= {r_rxd_s2, r_shift[7:1]};
      end

      if (w_stop_bad) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_ld_state <= L_IDLE;
    else       r_ld_state <= w_ld_next;
  end

  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      L_IDLE: if (en && !done) w_ld_next = L_RECV;
      L_RECV: begin
        if (!en)                                      w_ld_next = L_IDLE;
        else if (w_byte_valid && r_byte_cnt == 2'd3) w_ld_next = L_WRITE;
      end
      L_WRITE: begin
        if (w_last_word) w_ld_next = L_DONE;
        else if (en)     w_ld_next = L_RECV;
        else             w_ld_next = L_IDLE;
      end
      L_DONE:  w_ld_next = L_DONE;
      default: w_ld_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_ld_state)
        L_RECV: begin
          if (!en) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
          end else if (w_byte_valid) begin
            r_word     <= {r_word[15:0], r_shift};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            // Output registers only move on a real write so they hold otherwise.
            if (r_byte_cnt == 2'd3) begin
              r_wr_data <= {r_word, r_shift};
              r_wr_addr <= word_count[INST_SIZE-1:0];
            end
          end
        end
        L_WRITE: begin
          word_count <= w_count_inc;
          r_byte_cnt <= '0;
          r_word     <= '0;
          if (r_wr_data == C_SENTINEL) begin
            done <= 1'b1;
          end else if (w_count_inc == C_CAPACITY) begin
            done     <= 1'b1;
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_en   = (r_ld_state == L_WRITE);
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_inst_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboarded bench: a byte-level model predicts BRAM writes and final status.
module tb_uart_inst_loader;

  localparam int HALF = 4;
  localparam int ISZ  = 4;
  localparam int BIT  = 2 * HALF;
  localparam int CAP  = 1 << ISZ;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic rxd = 1'b1;
  logic [ISZ:0] word_count;
  logic done, overflow, frame_err;

  uart_inst_loader_if #(.INST_SIZE(ISZ)) bus ();

  uart_inst_loader #(.CLK_PER_HALF_BIT(HALF), .INST_SIZE(ISZ)) dut (
    .clk(clk), .rstn(rstn), .en(en), .rxd(rxd), .bus(bus.master),
    .word_count(word_count), .done(done), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [35:0] exp_q[$];
  logic [35:0] m_last;
  logic [7:0]  m_buf[$];
  int          m_count;
  bit          m_done, m_ovf, m_ferr, m_en;
  logic [35:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: actual addr %0d data %h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(mon_e));
      end
    end
  end

  // Loader semantics: four accepted bytes form one big-endian word at the next address.
  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (m_done || !m_en) return;
    m_buf.push_back(b);
    if (m_buf.size() == 4) begin
      w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
      m_last = {4'(m_count), w};
      exp_q.push_back(m_last);
      m_count++;
      m_buf.delete();
      if (w == 32'h0000_003F) m_done = 1;
      else if (m_count == CAP) begin
        m_done = 1;
        m_ovf  = 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else m_ferr = 1;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic glitch();
    rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic set_en(input bit v);
    en = v;
    m_en = v;
    if (!v) m_buf.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
    m_buf.delete();
    m_count = 0;
    m_done = 0;
    m_ovf = 0;
    m_ferr = 0;
    m_last = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'(m_count));
    check({tag, "_done"},       64'(done),       64'(m_done));
    check({tag, "_overflow"},   64'(overflow),   64'(m_ovf));
    check({tag, "_frame_err"},  64'(frame_err),  64'(m_ferr));
  endtask

  initial begin
    logic [31:0] w;
    int nwords;
    m_en = 0;
    do_reset(4);
    check("reset_outputs", 64'({bus.wr_en, bus.wr_addr, bus.wr_data, word_count,
                                done, overflow, frame_err}), 64'd0);

    // Two words ending with the sentinel.
    set_en(1);
    send_word(32'h1234_5678);
    send_word(32'h0000_003F);
    check_status("sentinel");

    // Traffic after done is ignored and the write port holds.
    send_word(32'hAABB_CCDD);
    check_status("after_done");
    check("hold_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(m_last));

    // Fill the whole memory without a sentinel, then try one more word.
    do_reset(1);
    set_en(1);
    for (int i = 0; i < CAP; i++) send_word(32'(i + 1));
    send_word(32'h0000_0099);
    check_status("overflow");

    // Framing error followed by a good word.
    do_reset(1);
    set_en(1);
    send_byte(8'h55, 1'b0);
    send_word(32'h0102_0304);
    check_status("frame_err");

    // Short low pulse must not be taken as a start bit.
    glitch();
    glitch();
    check_status("glitch");

    // Reset mid-word discards the partial word.
    do_reset(1);
    set_en(1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_reset(1);
    send_word(32'h0000_003F);
    check_status("reset_midword");

    // Dropping en mid-word discards the partial word too.
    do_reset(1);
    set_en(1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    set_en(0);
    set_en(1);
    send_word(32'h0000_003F);
    check_status("en_drop");

    // Randomised streams with glitches, framing errors and en toggles.
    for (int run = 0; run < 5; run++) begin
      do_reset(1);
      set_en(1);
      nwords = $urandom_range(4, 12);
      for (int k = 0; k < nwords; k++) begin
        w = ($urandom_range(0, 5) == 0) ? 32'h0000_003F : $urandom();
        for (int i = 3; i >= 0; i--) begin
          if ($urandom_range(0, 9) == 0) glitch();
          if ($urandom_range(0, 11) == 0) send_byte(8'($urandom()), 1'b0);
          if ($urandom_range(0, 14) == 0) begin
            set_en(0);
            set_en(1);
          end
          send_byte(w[8*i +: 8], 1'b1);
        end
      end
      check_status("random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
